// File: rtl/record_pkg.sv
// Shared field layout of the 44-bit pulse record and the decoded event.
// The epoch is carried beside evt_t because its width is a unit parameter.
package record_pkg;

    localparam int REC_TIMER_W  = 39;
    localparam int REC_MARK_BIT = 39;
    localparam int REC_CHAN_LSB = 40;
    localparam int REC_CHAN_W   = 4;
    localparam int REC_W        = 44;

    typedef struct packed {
        logic [REC_TIMER_W-1:0] timer;
        logic [REC_CHAN_W-1:0]  channel;
        logic                   marker;
    } evt_t;

    function automatic logic [REC_CHAN_W-1:0] rec_chan(
        input logic [REC_W-1:0] r
    );
        return r[REC_W-1:REC_CHAN_LSB];
    endfunction

endpackage

// File: rtl/record_unpacker_if.sv
// Record input strobe and event output stream of the unpacker.
// slave: unpacker side; master: record source / host readout side.
interface record_unpacker_if
    import record_pkg::*;
#(
    parameter int EPOCH_W = 9
);
    logic [REC_W-1:0]               rec_data;
    logic                           rec_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [REC_TIMER_W+EPOCH_W-1:0] out_time;
    logic [REC_CHAN_W-1:0]          out_channel;
    logic                           out_marker;

    modport slave (
        input  rec_data, rec_ready, out_ready,
        output out_valid, out_time, out_channel, out_marker
    );

    modport master (
        output rec_data, rec_ready, out_ready,
        input  out_valid, out_time, out_channel, out_marker
    );
endinterface

// File: rtl/record_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a push
// in the same cycle. Ports: clk, clear_n, push/din, pop/dout, full, empty.
module record_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/record_unpacker.sv
// Decodes pulse records, extends the timer with a rollover epoch and
// buffers events for the host stream. Ports: clk, clear_n, bus (record
// in, event stream out), drop_count, epoch_ovf.
// UNPACK_MARKER_PASS_EN: also forward marker-only records as events.
module record_unpacker
    import record_pkg::*;
#(
    parameter int EPOCH_W = 9,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               clear_n,
    record_unpacker_if.slave   bus,
    output logic [15:0]        drop_count,
    output logic               epoch_ovf
);
    localparam int EW = $bits(evt_t);
    localparam int FW = EPOCH_W + EW;

    logic [REC_TIMER_W-1:0] r_timer;
    logic                   r_mark;
    logic [REC_CHAN_W-1:0]  r_chan;
    logic                   mk_only;
    logic                   want;

    logic [EPOCH_W-1:0]     epoch;
    logic [EPOCH_W-1:0]     epoch_next;
    logic                   mark_seen;

    logic                   d_valid;
    logic [EPOCH_W-1:0]     d_epoch;
    evt_t                   d_evt;

    logic [FW-1:0]          f_dout;
    logic                   f_full;
    logic                   f_empty;
    logic                   pop;
    logic                   drop;
    evt_t                   q_evt;
    logic [EPOCH_W-1:0]     q_epoch;

    assign r_timer = bus.rec_data[REC_TIMER_W-1:0];
    assign r_mark  = bus.rec_data[REC_MARK_BIT];
    assign r_chan  = rec_chan(bus.rec_data);

`ifdef UNPACK_MARKER_PASS_EN
    assign mk_only = r_mark && (r_chan == '0);
    assign want    = bus.rec_ready && ((r_chan != '0) || r_mark);
`else
    assign mk_only = 1'b0;
    assign want    = bus.rec_ready && (r_chan != '0);
`endif

    // A marker in the same record stamps its event with the new epoch.
    assign epoch_next = (bus.rec_ready && r_mark) ?
                        epoch + EPOCH_W'(1) : epoch;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            epoch     <= '1;
            mark_seen <= 1'b0;
            epoch_ovf <= 1'b0;
            d_valid   <= 1'b0;
            d_epoch   <= '0;
            d_evt     <= '0;
        end else begin
            epoch   <= epoch_next;
            d_valid <= want;
            d_epoch <= epoch_next;
            d_evt.timer   <= mk_only ? '0 : r_timer;
            d_evt.channel <= r_chan;
            d_evt.marker  <= mk_only;
            if (bus.rec_ready && r_mark) begin
                mark_seen <= 1'b1;
                // The all-ones reset value wraps on the first marker
                // by design; only later wraps are overflows.
                if (mark_seen && (&epoch))
                    epoch_ovf <= 1'b1;
            end
        end
    end

    assign pop  = bus.out_valid && bus.out_ready;
    assign drop = d_valid && f_full && !pop;

    record_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (d_valid),
        .din     ({d_epoch, d_evt}),
        .pop     (pop),
        .dout    (f_dout),
        .full    (f_full),
        .empty   (f_empty)
    );

    always_ff @(posedge clk) begin
        if (!clear_n)
            drop_count <= '0;
        else if (drop && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end

    assign q_evt   = f_dout[EW-1:0];
    assign q_epoch = f_dout[FW-1:EW];

    // Gated so the stream reads zero while empty.
    assign bus.out_valid   = !f_empty;
    assign bus.out_time    = f_empty ? '0 : {q_epoch, q_evt.timer};
    assign bus.out_channel = f_empty ? '0 : q_evt.channel;

`ifdef UNPACK_MARKER_PASS_EN
    assign bus.out_marker  = !f_empty && q_evt.marker;
`else
    logic unused_marker;
    assign unused_marker  = q_evt.marker;
    assign bus.out_marker = 1'b0;
`endif

endmodule

// File: tb/tb_record_unpacker.sv
// Directed bench for record_unpacker: latency, epoch stamping, drops,
// full push+pop, epoch wrap on a 2-bit instance, and mid-run reset.
module tb_record_unpacker;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [15:0] drop0;
    logic [15:0] drop1;
    logic        ovf0;
    logic        ovf1;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    record_unpacker_if #(.EPOCH_W(9)) b0 ();
    record_unpacker_if #(.EPOCH_W(2)) b1 ();

    record_unpacker #(.EPOCH_W(9), .DEPTH(16)) u0 (
        .clk        (clk),
        .clear_n    (clear_n),
        .bus        (b0.slave),
        .drop_count (drop0),
        .epoch_ovf  (ovf0)
    );

    record_unpacker #(.EPOCH_W(2), .DEPTH(4)) u1 (
        .clk        (clk),
        .clear_n    (clear_n),
        .bus        (b1.slave),
        .drop_count (drop1),
        .epoch_ovf  (ovf1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] rec(input logic [3:0] ch,
                                        input logic mk,
                                        input logic [38:0] t);
        return {ch, mk, t};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        step(1);
        clear_n = 1'b1;
    endtask

    task automatic send0(input logic [43:0] r);
        b0.rec_data  = r;
        b0.rec_ready = 1'b1;
        step(1);
        b0.rec_ready = 1'b0;
    endtask

    task automatic expect0(input string tag, input logic [8:0] ep,
                           input logic [38:0] t, input logic [3:0] ch,
                           input logic mk);
        int k = 0;
        while (!b0.out_valid && k < 10) begin
            step(1);
            k++;
        end
        if (!b0.out_valid) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_time"}, b0.out_time, {ep, t});
            check({tag, "_chan"}, b0.out_channel, ch);
            check({tag, "_mark"}, b0.out_marker, mk);
            b0.out_ready = 1'b1;
            step(1);
            b0.out_ready = 1'b0;
        end
    endtask

    // Called right after a marker-only record with the FIFO empty.
    task automatic mark_ev0(input string tag, input logic [8:0] ep);
`ifdef UNPACK_MARKER_PASS_EN
        expect0(tag, ep, 39'd0, 4'h0, 1'b1);
`else
        logic [8:0] unused_ep;
        unused_ep = ep;
        step(2);
        check({tag, "_none"}, b0.out_valid, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] e;
        b0.rec_data  = '0;
        b0.rec_ready = 1'b0;
        b0.out_ready = 1'b0;
        b1.rec_data  = '0;
        b1.rec_ready = 1'b0;
        b1.out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", b0.out_valid, 1'b0);
        check("rst_time", b0.out_time, 48'd0);
        check("rst_chan", b0.out_channel, 4'h0);
        check("rst_mark", b0.out_marker, 1'b0);
        check("rst_drop", drop0, 16'd0);
        check("rst_ovf", ovf0, 1'b0);

        // First marker gives epoch 0; event shows 2 cycles after strobe
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("m0", 9'd0);
        send0(rec(4'h2, 1'b0, 39'd5));
        check("lat_n1", b0.out_valid, 1'b0);
        step(1);
        check("lat_n2", b0.out_valid, 1'b1);
        expect0("ev5", 9'd0, 39'd5, 4'h2, 1'b0);

        // Same-record marker applied before stamping
        do_reset();
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("m2a", 9'd0);
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("m2b", 9'd1);
        send0(rec(4'h1, 1'b1, 39'd0));
        expect0("ev_mk", 9'd2, 39'd0, 4'h1, 1'b0);

        // Fill with DEPTH+3 events, epoch still at reset value
        do_reset();
        for (int i = 1; i <= 19; i++)
            send0(rec(4'h4, 1'b0, 39'(i)));
        step(2);
        check("fill_drop", drop0, 16'd3);
        check("fill_valid", b0.out_valid, 1'b1);
        expect0("fill_1", 9'h1FF, 39'd1, 4'h4, 1'b0);
        send0(rec(4'h4, 1'b0, 39'd100));
        step(1);
        check("refill_drop", drop0, 16'd3);

        // Full FIFO: push and pop in the same cycle
        send0(rec(4'h4, 1'b0, 39'd200));
        b0.out_ready = 1'b1;
        step(1);
        b0.out_ready = 1'b0;
        check("pp_drop", drop0, 16'd3);
        for (int i = 3; i <= 16; i++)
            expect0($sformatf("drain_%0d", i), 9'h1FF, 39'(i),
                    4'h4, 1'b0);
        expect0("drain_100", 9'h1FF, 39'd100, 4'h4, 1'b0);
        expect0("drain_200", 9'h1FF, 39'd200, 4'h4, 1'b0);
        check("drain_empty", b0.out_valid, 1'b0);

        // Events interleaved with markers
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("im0", 9'd0);
        send0(rec(4'h3, 1'b0, 39'd7));
        expect0("iev7", 9'd0, 39'd7, 4'h3, 1'b0);
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("im1", 9'd1);
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("im2", 9'd2);
        send0(rec(4'hA, 1'b0, 39'd9));
        expect0("iev9", 9'd2, 39'd9, 4'hA, 1'b0);
        check("i_ovf", ovf0, 1'b0);

        // 2-bit epoch wrap
        do_reset();
        for (int k = 0; k < 5; k++) begin
            e = 2'(k);
            b1.rec_data  = rec(4'h1, 1'b1, 39'(k));
            b1.rec_ready = 1'b1;
            step(1);
            b1.rec_ready = 1'b0;
            step(1);
            check($sformatf("w%0d_valid", k), b1.out_valid, 1'b1);
            check($sformatf("w%0d_time", k), b1.out_time, {e, 39'(k)});
            check($sformatf("w%0d_ovf", k), ovf1, (k == 4));
            b1.out_ready = 1'b1;
            step(1);
            b1.out_ready = 1'b0;
        end
        check("w_drop", drop1, 16'd0);

        // Reset with 4 events buffered and a record in the reset cycle
        do_reset();
        for (int i = 0; i < 4; i++)
            send0(rec(4'h5, 1'b0, 39'(10 + i)));
        step(2);
        check("mid_valid", b0.out_valid, 1'b1);
        clear_n      = 1'b0;
        b0.rec_data  = rec(4'h1, 1'b0, 39'd99);
        b0.rec_ready = 1'b1;
        step(1);
        clear_n      = 1'b1;
        b0.rec_ready = 1'b0;
        check("mid_rst_valid", b0.out_valid, 1'b0);
        step(3);
        check("mid_rst_disc", b0.out_valid, 1'b0);
        send0(rec(4'h0, 1'b1, 39'd0));
        mark_ev0("mid_m", 9'd0);
        send0(rec(4'h1, 1'b0, 39'd3));
        expect0("mid_ev", 9'd0, 39'd3, 4'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/record_unpacker.md
# record_unpacker

Consumer for the 44-bit pulse records emitted by the pulse registration stage. It decodes each record, counts rollover markers to extend the 39-bit timer into a monotonic wide timestamp, and buffers decoded events in a small FIFO. The FIFO is presented on a valid/ready stream toward the host readout path. It sits directly behind the registration stage, one per acquisition board.

## Interface
Parameters:
- `EPOCH_W`, 9: rollover-epoch counter width; output time width is `39+EPOCH_W`.
- `DEPTH`, 16: event FIFO depth, power of two, ≥4.

Ports:
- `clk`, in, 1: single clock, shared with the registration stage.
- `clear_n`, in, 1: synchronous active-low reset.
- `rec_data`, in, 44: record with fields [38:0] timer, [39] rollover marker, [43:40] channel mask.
- `rec_ready`, in, 1: one-cycle strobe qualifying `rec_data`. No backpressure is possible; the source cannot stall.
- `out_valid`, out, 1: event available.
- `out_ready`, in, 1: downstream accepts the event.
- `out_time`, out, 39+EPOCH_W: extended timestamp `{epoch, timer}`.
- `out_channel`, out, 4: channel mask. Multiple bits set means coincident pulses.
- `out_marker`, out, 1: record was a marker-only record. Used only with the macro defined; otherwise tied 0.
- `drop_count`, out, 16: saturating count of events lost to FIFO full.
- `epoch_ovf`, out, 1: sticky; set when the epoch counter wraps.

## Operation
- **Decode stage (registered).** On `rec_ready`:
  - If bit 39 = 1, `epoch <= epoch + 1` (mod 2^EPOCH_W).
  - If channel ≠ 0, push event `{epoch_next, timer, channel}`. `epoch_next` is the incremented value when bit 39 = 1 in the same record.
- Records with channel = 0 and bit 39 = 0 are ignored.
- **Epoch reset value.** `epoch` resets to all-ones, so the first marker after clear (timer = 0) yields epoch 0.
- **Epoch wrap.** When `epoch` wraps from all-ones to 0, except on the first marker after reset, set `epoch_ovf`. It clears only on reset.
- **Epoch independence.** Epoch updates happen regardless of FIFO state; markers are never lost.
- **FIFO full.** A push while full drops the event and increments `drop_count`, which saturates at 0xFFFF.
- **Output stream.** First-word-fall-through. Transfer occurs when `out_valid && out_ready`. Outputs hold stable while `out_valid && !out_ready`.
- **Simultaneous push and pop while full.** Both succeed; nothing is dropped.
- **Reset values.** `out_valid` 0, `out_time` 0, `out_channel` 0, `out_marker` 0, `drop_count` 0, `epoch_ovf` 0. FIFO is emptied and `epoch` is set to all-ones.
- **Reset mid-operation.** Reset discards buffered events and any record arriving in the reset cycle.

## Timing
- Latency: `rec_ready` in cycle N with the FIFO empty gives `out_valid` = 1 in cycle N+2 (decode register at N+1, FIFO output at N+2).
- Throughput: one record per cycle in, one event per cycle out.
- The full decision uses FIFO occupancy after the same-cycle pop.
- Back-to-back markers in consecutive cycles each increment `epoch`.

## Configuration
- `UNPACK_MARKER_PASS_EN`:
  - **Defined:** marker-only records (bit 39 = 1, channel 0) are also pushed as events with `out_marker` = 1, `out_channel` = 0 and `out_time` = `{new epoch, 39'd0}`. They are subject to the same drop rule.
  - **Undefined:** markers are consumed internally and `out_marker` is constant 0.

## Structure
- **Package `record_pkg`:**
  - field constants `REC_TIMER_W` = 39, `REC_MARK_BIT` = 39, `REC_CHAN_LSB` = 40, `REC_W` = 44;
  - the event struct typedef (time, channel, marker).
- **Sub-module `record_fifo`:** synchronous FWFT FIFO, parameterised by width and depth. It exposes full, empty and push/pop. The unpacker owns decode, epoch and drop logic.

## Test plan
- Reset, then marker `{0x0, 1, 0}`, then event ch 0x2 at timer 5 → one event with time = 5, channel 0x2, epoch 0, appearing 2 cycles after its strobe.
- Two markers, then an event ch 0x1 with bit 39 = 1 and timer 0 → time = `{2, 39'd0}`. The same-record marker is applied before stamping.
- Hold `out_ready` = 0 and send DEPTH+3 events → FIFO full, `drop_count` = 3. Events interleaved with markers advance the epoch on later drains correctly.
- Full FIFO with `out_ready` = 1 and a push in the same cycle → no drop, `drop_count` unchanged.
- EPOCH_W = 2, five markers → epoch sequence 0, 1, 2, 3, 0, and `epoch_ovf` = 1 after the fifth.
- Assert `clear_n` = 0 for one cycle with 4 events buffered → `out_valid` = 0 next cycle. A subsequent marker gives epoch 0. With `UNPACK_MARKER_PASS_EN` defined, that marker emerges with `out_marker` = 1.
